// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// Multiplies finish in MUL_CYCLES; divides take 32 restoring steps plus one sign-fix cycle.
module muldiv_unit #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        op_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int DIV_CYCLES = 33;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic        accept, mul_last, div_last, signed_op;

  logic [31:0] hi_reg, lo_reg;
  logic [31:0] a_reg, b_reg, rem_reg, quo_reg;
  logic        is_signed_reg, q_neg_reg, r_neg_reg, div_zero_reg;
  logic [63:0] product;
  logic [32:0] shifted, trial;

  assign busy      = (state_reg != IDLE);
  assign op_ready  = ~busy;
  assign accept    = op_valid & op_ready & ~flush;
  assign mul_last  = (state_reg == MUL) && (cnt_reg == 6'(MUL_CYCLES - 1));
  assign div_last  = (state_reg == DIV) && (cnt_reg == 6'(DIV_CYCLES - 1));
  assign done      = mul_last | div_last;
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign hi        = hi_reg;
  assign lo        = lo_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next = '0;
          if (op == OP_MULT || op == OP_MULTU)
            state_next = MUL;
          else if (op == OP_DIV || op == OP_DIVU)
            state_next = DIV;
        end
      end
      MUL, DIV: begin
        if (done) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 6'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  // Low 64 bits of the extended product are correct for both signed and unsigned forms.
  assign product = {{32{is_signed_reg & a_reg[31]}}, a_reg} *
                   {{32{is_signed_reg & b_reg[31]}}, b_reg};
  assign shifted = {rem_reg, quo_reg[31]};
  assign trial   = shifted - {1'b0, b_reg};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_reg        <= '0;
      lo_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      is_signed_reg <= 1'b0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      div_zero_reg  <= 1'b0;
    end else begin
      if (accept) begin
        case (op)
          OP_MTHI: hi_reg <= a;
          OP_MTLO: lo_reg <= a;
          OP_MULT, OP_MULTU: begin
            a_reg         <= a;
            b_reg         <= b;
            is_signed_reg <= signed_op;
          end
          OP_DIV, OP_DIVU: begin
            // Divide on magnitudes; b_reg holds the divisor, quo_reg shifts the dividend out.
            rem_reg      <= '0;
            quo_reg      <= (signed_op && a[31]) ? -a : a;
            b_reg        <= (signed_op && b[31]) ? -b : b;
            q_neg_reg    <= signed_op && (a[31] ^ b[31]);
            r_neg_reg    <= signed_op && a[31];
            div_zero_reg <= (b == '0);
          end
          default: ;
        endcase
      end
      if (state_reg == DIV && !div_last) begin
        if (!trial[32]) begin
          rem_reg <= trial[31:0];
          quo_reg <= {quo_reg[30:0], 1'b1};
        end else begin
          rem_reg <= shifted[31:0];
          quo_reg <= {quo_reg[30:0], 1'b0};
        end
      end
      if (done && !flush) begin
        if (mul_last) begin
          {hi_reg, lo_reg} <= product;
        end else if (!div_zero_reg) begin
          lo_reg <= q_neg_reg ? -quo_reg : quo_reg;
          hi_reg <= r_neg_reg ? -rem_reg : rem_reg;
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// compared against an arithmetic HI/LO model.
module tb_muldiv_unit;
  localparam int MUL_CYCLES = 2;
  localparam int DIV_CYCLES = 33;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        op_ready, busy, done;
  logic [31:0] hi, lo;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  muldiv_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .flush(flush), .op_ready(op_ready), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2) return MUL_CYCLES;
    if (o == 3'd3 || o == 3'd4) return DIV_CYCLES;
    return 0;
  endfunction

  // Reference model: plain 64-bit arithmetic with the architectural divide rules.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sp, sq, sr;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd1: begin sp = sx * sy; {hi_m, lo_m} = sp; end
      3'd2: begin up = {32'b0, x} * {32'b0, y}; {hi_m, lo_m} = up; end
      3'd3: if (y != 0) begin
        sq = sx / sy; sr = sx % sy;
        lo_m = sq[31:0]; hi_m = sr[31:0];
      end
      3'd4: if (y != 0) begin lo_m = x / y; hi_m = x % y; end
      3'd5: hi_m = x;
      3'd6: lo_m = x;
      default: ;
    endcase
  endtask

  // Counts busy cycles from the current sample point until the unit is idle again.
  task automatic measure(input string tag, input int exp);
    int n, done_at, done_cnt;
    n = 0; done_at = 0; done_cnt = 0;
    while (busy && n < 100) begin
      n++;
      if (done) begin done_at = n; done_cnt++; end
      @(posedge clk); #1;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp));
    check({tag, "_done_at"}, 64'(done_at), 64'(exp));
    check({tag, "_done_cnt"}, 64'(done_cnt), (exp > 0) ? 64'd1 : 64'd0);
    check({tag, "_idle"}, {62'b0, op_ready, done}, 64'b10);
  endtask

  task automatic exec(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    model_apply(o, x, y);
    measure($sformatf("op%0d", o), lat(o));
    check($sformatf("op%0d_hi", o), 64'(hi), 64'(hi_m));
    check($sformatf("op%0d_lo", o), 64'(lo), 64'(lo_m));
    $display("[TB] op=%0d a=%08h b=%08h -> hi=%08h lo=%08h", o, x, y, hi, lo);
  endtask

  task automatic expect_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    check({tag, "_hilo"}, {hi, lo}, {eh, el});
  endtask

  task automatic start_div(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op_valid = 1'b1; op = 3'd3; a = x; b = y;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [2:0] o;
    logic [31:0] x, y;

    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(op_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    expect_hilo("rst", 32'h0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    exec(3'd5, 32'h12345678, 32'h0);
    exec(3'd6, 32'h9ABCDEF0, 32'h0);
    expect_hilo("mt", 32'h12345678, 32'h9ABCDEF0);
    exec(3'd1, 32'hFFFFFFFF, 32'd2);
    expect_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);
    exec(3'd2, 32'hFFFFFFFF, 32'd2);
    expect_hilo("multu", 32'h00000001, 32'hFFFFFFFE);
    exec(3'd3, 32'hFFFFFFF9, 32'd2);
    expect_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    exec(3'd4, 32'd100, 32'd7);
    expect_hilo("divu", 32'd2, 32'd14);
    exec(3'd3, 32'h80000000, 32'hFFFFFFFF);
    expect_hilo("div_ovf", 32'h0, 32'h80000000);
    exec(3'd4, 32'd5, 32'd0);
    expect_hilo("divu_zero", 32'h0, 32'h80000000);
    exec(3'd0, 32'hAAAA5555, 32'h1);
    exec(3'd7, 32'h5555AAAA, 32'h1);

    // A MULTU held on the bus while a DIV runs is taken the cycle after done.
    @(negedge clk);
    op_valid = 1'b1; op = 3'd3; a = 32'hFFFFFF9C; b = 32'd7;
    @(posedge clk); #1;
    op = 3'd2; a = 32'h00010000; b = 32'h00010000;
    n = 1;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    check("b2b_div_lat", 64'(n), 64'(DIV_CYCLES));
    check("b2b_held_ready", 64'(op_ready), 64'd0);
    @(posedge clk); #1;
    model_apply(3'd3, 32'hFFFFFF9C, 32'd7);
    check("b2b_idle_ready", 64'(op_ready), 64'd1);
    expect_hilo("b2b_div", 32'hFFFFFFFE, 32'hFFFFFFF2);
    @(posedge clk); #1;
    op_valid = 1'b0;
    model_apply(3'd2, 32'h00010000, 32'h00010000);
    measure("b2b_mul", MUL_CYCLES);
    expect_hilo("b2b_mul", 32'h1, 32'h0);
    $display("[TB] back-to-back DIV+MULTU -> hi=%08h lo=%08h", hi, lo);

    exec(3'd5, 32'h11111111, 32'h0);
    exec(3'd6, 32'h22222222, 32'h0);

    // MTHI presented with flush must not write.
    @(negedge clk);
    op_valid = 1'b1; op = 3'd5; a = 32'hDEADBEEF; flush = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    check("mt_flush_busy", 64'(busy), 64'd0);
    expect_hilo("mt_flush", 32'h11111111, 32'h22222222);
    $display("[TB] flushed MTHI -> hi=%08h", hi);

    start_div(32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    check("fl10_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl10_busy", 64'(busy), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    check("fl10_stay_idle", 64'(busy), 64'd0);
    expect_hilo("fl10", 32'h11111111, 32'h22222222);
    $display("[TB] DIV flushed in cycle 10 -> hi=%08h lo=%08h", hi, lo);

    start_div(32'd1000, 32'd3);
    repeat (DIV_CYCLES - 1) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    check("fldone_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    check("fldone_busy", 64'(busy), 64'd0);
    expect_hilo("fldone", 32'h11111111, 32'h22222222);
    $display("[TB] DIV flushed with done -> hi=%08h lo=%08h", hi, lo);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0: y = 32'h0;
        1: y = 32'hFFFFFFFF;
        2: y = 32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      exec(o, x, y);
    end

    // Asynchronous reset in the middle of a multiply.
    exec(3'd5, 32'hCAFEF00D, 32'h0);
    @(negedge clk);
    op_valid = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("rstmid_busy_before", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    hi_m = '0; lo_m = '0;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_ready", 64'(op_ready), 64'd1);
    expect_hilo("rstmid", hi_m, lo_m);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("rstmid_after_busy", 64'(busy), 64'd0);
    expect_hilo("rstmid_after", 32'h0, 32'h0);
    $display("[TB] reset mid-MULT -> hi=%08h lo=%08h", hi, lo);
    exec(3'd2, 32'd6, 32'd7);
    expect_hilo("post_rst", 32'h0, 32'd42);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
